// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined chunked add/subtract with valid/ready handshake and ALU condition flags
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             lt,
  output logic             ltu
);
  localparam int C = WIDTH / STAGES;
  // Register 0 captures the raw operation; registers 1..STAGES each add one chunk.
  logic [STAGES:0]   v, c;
  logic [STAGES-1:0] s, nc;
  logic [WIDTH-1:0]  x  [STAGES];
  logic [WIDTH-1:0]  b  [STAGES];
  logic [WIDTH-1:0]  r  [STAGES+1];
  logic [WIDTH-1:0]  nr [STAGES];
  logic [C-1:0]      ch;
  logic              adv, f_ovf;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v[STAGES];
  assign result    = r[STAGES];
  assign negative  = r[STAGES][WIDTH-1];
  assign carry     = c[STAGES];
  always_comb begin
    ch = '0;
    nc = '0;
    for (int k = 0; k < STAGES; k++) begin
      nr[k] = r[k];
      {nc[k], ch} = {1'b0, x[k][k*C +: C]} + {1'b0, b[k][k*C +: C]} + {{C{1'b0}}, c[k]};
      nr[k][k*C +: C] = ch;
    end
    f_ovf = (x[STAGES-1][WIDTH-1] == b[STAGES-1][WIDTH-1]) &&
            (nr[STAGES-1][WIDTH-1] != x[STAGES-1][WIDTH-1]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v        <= '0;
      c        <= '0;
      s        <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      lt       <= 1'b0;
      ltu      <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x[k] <= '0;
        b[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) r[k] <= '0;
    end else if (adv) begin
      v[0] <= in_valid;
      c[0] <= sub;
      s[0] <= sub;
      x[0] <= X;
      b[0] <= sub ? ~Y : Y;
      r[0] <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        v[k] <= v[k-1];
        c[k] <= nc[k-1];
        r[k] <= nr[k-1];
      end
      for (int k = 1; k < STAGES; k++) begin
        s[k] <= s[k-1];
        x[k] <= x[k-1];
        b[k] <= b[k-1];
      end
      zero     <= ~|nr[STAGES-1];
      overflow <= f_ovf;
      lt       <= s[STAGES-1] & (nr[STAGES-1][WIDTH-1] ^ f_ovf);
      ltu      <= s[STAGES-1] & ~nc[STAGES-1];
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed and randomized checks of addsub_pipe against an arithmetic reference model
module tb_addsub_pipe;
  localparam int W = 32;
  localparam int S = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 0;
  logic [W-1:0] X = '0, Y = '0;
  logic in_ready, out_valid, zero, negative, carry, overflow, lt, ltu;
  logic [W-1:0] result;
  int checks = 0, passed = 0;
  logic [W+5:0] q[$];
  wire [W+5:0] obs = {result, zero, negative, carry, overflow, lt, ltu};

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .lt(lt), .ltu(ltu));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // {result, zero, negative, carry, overflow, lt, ltu} from plain integer arithmetic
  function automatic logic [W+5:0] model(input logic [W-1:0] a, input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    logic cy, ov, slt, ult;
    logic signed [W:0] sw;
    ult = a < d;
    slt = $signed(a) < $signed(d);
    if (m) begin
      r  = a - d;
      cy = !ult;
      sw = $signed({a[W-1], a}) - $signed({d[W-1], d});
    end else begin
      {cy, r} = {1'b0, a} + {1'b0, d};
      sw = $signed({a[W-1], a}) + $signed({d[W-1], d});
    end
    ov = sw[W] != sw[W-1];
    return {r, r == '0, r[W-1], cy, ov, m & slt, m & ult};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return {1'b0, {(W-1){1'b1}}};
      4: return {1'b1, {(W-1){1'b0}}};
      5: return W'($urandom_range(0, 3)) << (W/2 - 1);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_state: got valid=%b obs=%h ready=%b required valid=0 obs=0 ready=1", out_valid, obs, in_ready);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_directed();
    logic [W-1:0] tx[6], ty[6];
    logic ts[6];
    logic [W+5:0] te[6];
    tx[0] = 32'h1;        ty[0] = 32'h1; ts[0] = 1; te[0] = {32'h0,        6'b101000};
    tx[1] = 32'h0;        ty[1] = 32'h1; ts[1] = 1; te[1] = {32'hFFFFFFFF, 6'b010011};
    tx[2] = 32'h7FFFFFFF; ty[2] = 32'h1; ts[2] = 0; te[2] = {32'h80000000, 6'b010100};
    tx[3] = 32'h80000000; ty[3] = 32'h1; ts[3] = 1; te[3] = {32'h7FFFFFFF, 6'b001110};
    tx[4] = 32'h0000FFFF; ty[4] = 32'h1; ts[4] = 0; te[4] = {32'h00010000, 6'b000000};
    tx[5] = 32'hFFFFFFFF; ty[5] = 32'h1; ts[5] = 0; te[5] = {32'h0,        6'b101000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      X = tx[i]; Y = ty[i]; sub = ts[i]; in_valid = 1; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      repeat (S-1) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL early_valid[%0d]: got out_valid=%b required 0", i, out_valid);
      else passed++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || obs !== te[i])
        $display("FAIL directed[%0d]: got valid=%b obs=%h required valid=1 obs=%h", i, out_valid, obs, te[i]);
      else passed++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL bubble_after[%0d]: got out_valid=%b required 0", i, out_valid);
      else passed++;
    end
  endtask

  task automatic run_stream(input int nops, input bit pattern);
    int sent = 0, got = 0, cyc = 0;
    bit stall = 0;
    logic [W+5:0] held, exp;
    held = '0;
    while ((sent < nops || q.size() > 0 || out_valid === 1'b1) && cyc < 4000) begin
      @(negedge clk);
      in_valid  = (sent < nops) && (pattern || $urandom_range(0, 3) != 0);
      X = pick(); Y = pick(); sub = 1'($urandom_range(0, 1));
      out_ready = pattern ? (cyc % 4 == 0 || cyc % 4 == 3) : ($urandom_range(0, 2) != 0);
      #1;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held)
          $display("FAIL stall_hold: got valid=%b obs=%h required valid=1 obs=%h", out_valid, obs, held);
        else passed++;
      end
      if (out_valid === 1'b1 && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_ready: got in_ready=%b required 0", in_ready);
        else passed++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL spurious_out: got obs=%h required no output", obs);
        else begin
          exp = q.pop_front();
          if (obs !== exp) $display("FAIL stream_out[%0d]: got %h required %h", got, obs, exp);
          else passed++;
        end
        got++;
      end
      stall = (out_valid === 1'b1) && !out_ready;
      held  = obs;
      if (in_valid && in_ready) begin
        q.push_back(model(X, Y, sub));
        sent++;
      end
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    checks++;
    if (q.size() != 0 || got != sent || sent != nops)
      $display("FAIL stream_count: got sent=%0d out=%0d left=%0d required %0d/%0d/0", sent, got, q.size(), nops, nops);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [W+5:0] exp;
    @(negedge clk);
    X = 32'd10; Y = 32'd4; sub = 1; in_valid = 1; out_ready = 0;
    @(negedge clk);
    X = 32'd20; Y = 32'd7; sub = 0;
    @(negedge clk);
    in_valid = 0;
    repeat (S-1) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) $display("FAIL mid_precond: got out_valid=%b required 1", out_valid);
    else passed++;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs !== '0 || in_ready !== 1'b1)
      $display("FAIL mid_reset: got valid=%b obs=%h ready=%b required 0/0/1", out_valid, obs, in_ready);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1; out_ready = 1;
    q.delete();
    repeat (S+1) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL stale_out: got out_valid=%b required 0", out_valid);
      else passed++;
    end
    X = 32'd5; Y = 32'd3; sub = 1; in_valid = 1;
    exp = model(X, Y, sub);
    @(negedge clk);
    in_valid = 0;
    repeat (S-1) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL post_reset_early: got out_valid=%b required 0", out_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd2 || obs !== exp)
      $display("FAIL post_reset_op: got valid=%b obs=%h required valid=1 obs=%h", out_valid, obs, exp);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    run_stream(8, 1'b1);
    run_stream(300, 1'b0);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
